// File: rtl/sigpulse_pkg.sv
// Shared state encoding and default sizes for the sigpulse_mc pulse-train generator.
`timescale 1ns/1ps
package sigpulse_pkg;
  localparam int CH_NUM_DEF    = 4;
  localparam int RAM_WIDTH_DEF = 32;
  localparam int REP_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_GAP    = 2'd3
  } state_t;
endpackage

// File: rtl/sigpulse_ch.sv
// One pulse-train channel: delay/width/gap/repeat FSM; outputs lag the state by one register stage.
// Build option SIGPULSE_MC_RETRIG_EN: a trigger while busy restarts the run instead of being ignored.
`timescale 1ns/1ps
module sigpulse_ch
  import sigpulse_pkg::*;
#(
  parameter int RAM_W = RAM_WIDTH_DEF,
  parameter int REP_W = REP_WIDTH_DEF
) (
  input  logic             io_clk,
  input  logic             io_rst,
  input  logic             en,
  input  logic             dis,
  input  logic             default_level,
  input  logic [RAM_W-1:0] delay,
  input  logic [RAM_W-1:0] width,
  input  logic [RAM_W-1:0] gap,
  input  logic [REP_W-1:0] rep_num,
  output logic             pulse_out,
  output logic             busy,
  output logic             done
);
  localparam logic [RAM_W-1:0] CNT_ONE = RAM_W'(1);

  state_t           state;
  logic [RAM_W-1:0] cnt;
  logic [RAM_W-1:0] width_q;
  logic [RAM_W-1:0] gap_q;
  logic [REP_W-1:0] rep_q;
  logic [REP_W-1:0] pcnt;
  logic [REP_W-1:0] pcnt_inc;
  logic             act_q;
  logic             busy_q;
  logic             done_q;
  logic             start;

  assign pcnt_inc = pcnt + REP_W'(1);

`ifdef SIGPULSE_MC_RETRIG_EN
  assign start = en && (width != '0);
`else
  assign start = en && (width != '0) && (state == ST_IDLE);
`endif

  always_ff @(posedge io_clk or posedge io_rst) begin
    if (io_rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      width_q <= '0;
      gap_q   <= '0;
      rep_q   <= '0;
      pcnt    <= '0;
      act_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      act_q  <= (state == ST_ACTIVE);
      busy_q <= (state != ST_IDLE);
      done_q <= 1'b0;
      if (dis) begin
        state  <= ST_IDLE;
        cnt    <= '0;
        pcnt   <= '0;
        act_q  <= 1'b0;
        busy_q <= 1'b0;
      end else if (start) begin
        // Restart path also covers retrigger; it wins over any done due this cycle.
        width_q <= width;
        gap_q   <= gap;
        rep_q   <= rep_num;
        pcnt    <= '0;
        if (delay != '0) begin
          state <= ST_DELAY;
          cnt   <= delay;
        end else begin
          state <= ST_ACTIVE;
          cnt   <= width;
        end
      end else begin
        case (state)
          ST_DELAY, ST_GAP: begin
            if (cnt == CNT_ONE) begin
              state <= ST_ACTIVE;
              cnt   <= width_q;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
          ST_ACTIVE: begin
            if (cnt == CNT_ONE) begin
              if (rep_q != '0) pcnt <= pcnt_inc;
              if ((rep_q != '0) && (pcnt_inc == rep_q)) begin
                state  <= ST_IDLE;
                cnt    <= '0;
                pcnt   <= '0;
                done_q <= 1'b1;
              end else if (gap_q != '0) begin
                state <= ST_GAP;
                cnt   <= gap_q;
              end else begin
                cnt <= width_q;
              end
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  // Polarity is applied after the register so a level change is seen without relatching.
  assign pulse_out = dis ? default_level : (default_level ^ act_q);
  assign busy      = busy_q;
  assign done      = done_q;
endmodule

// File: rtl/sigpulse_mc.sv
// Multi-channel triggered pulse-train generator: independent sigpulse_ch per channel.
// Build option SIGPULSE_MC_RETRIG_EN enables retrigger-while-busy in every channel.
`timescale 1ns/1ps
module sigpulse_mc
  import sigpulse_pkg::*;
#(
  parameter int _CH_NUM    = CH_NUM_DEF,
  parameter int _RAM_WIDTH = RAM_WIDTH_DEF,
  parameter int _REP_WIDTH = REP_WIDTH_DEF
) (
  input  logic                           io_clk,
  input  logic                           io_rst,
  input  logic [_CH_NUM-1:0]             io_en,
  input  logic [_CH_NUM-1:0]             io_dis,
  input  logic [_CH_NUM-1:0]             io_defaultLevel,
  input  logic [_CH_NUM*_RAM_WIDTH-1:0]  io_delay,
  input  logic [_CH_NUM*_RAM_WIDTH-1:0]  io_width,
  input  logic [_CH_NUM*_RAM_WIDTH-1:0]  io_gap,
  input  logic [_CH_NUM*_REP_WIDTH-1:0]  io_repeat,
  output logic [_CH_NUM-1:0]             io_pulseOut,
  output logic [_CH_NUM-1:0]             io_busy,
  output logic [_CH_NUM-1:0]             io_done
);
  for (genvar k = 0; k < _CH_NUM; k++) begin : g_ch
    sigpulse_ch #(
      .RAM_W(_RAM_WIDTH),
      .REP_W(_REP_WIDTH)
    ) u_ch (
      .io_clk       (io_clk),
      .io_rst       (io_rst),
      .en           (io_en[k]),
      .dis          (io_dis[k]),
      .default_level(io_defaultLevel[k]),
      .delay        (io_delay[k*_RAM_WIDTH +: _RAM_WIDTH]),
      .width        (io_width[k*_RAM_WIDTH +: _RAM_WIDTH]),
      .gap          (io_gap[k*_RAM_WIDTH +: _RAM_WIDTH]),
      .rep_num      (io_repeat[k*_REP_WIDTH +: _REP_WIDTH]),
      .pulse_out    (io_pulseOut[k]),
      .busy         (io_busy[k]),
      .done         (io_done[k])
    );
  end
endmodule

// File: tb/tb_sigpulse_mc.sv
// Directed self-checking bench for sigpulse_mc; samples 1ns after each rising edge.
`timescale 1ns/1ps
module tb_sigpulse_mc;
  logic         io_clk;
  logic         io_rst;
  logic [3:0]   io_en;
  logic [3:0]   io_dis;
  logic [3:0]   io_defaultLevel;
  logic [127:0] io_delay;
  logic [127:0] io_width;
  logic [127:0] io_gap;
  logic [63:0]  io_repeat;
  logic [3:0]   io_pulseOut;
  logic [3:0]   io_busy;
  logic [3:0]   io_done;

  int total = 0;
  int bad   = 0;

  sigpulse_mc dut (
    .io_clk         (io_clk),
    .io_rst         (io_rst),
    .io_en          (io_en),
    .io_dis         (io_dis),
    .io_defaultLevel(io_defaultLevel),
    .io_delay       (io_delay),
    .io_width       (io_width),
    .io_gap         (io_gap),
    .io_repeat      (io_repeat),
    .io_pulseOut    (io_pulseOut),
    .io_busy        (io_busy),
    .io_done        (io_done)
  );

  initial io_clk = 1'b0;
  always #5 io_clk = ~io_clk;

  task automatic set_cfg(input int ch, input logic lvl, input int d, input int w,
                         input int g, input int r);
    io_defaultLevel[ch]  = lvl;
    io_delay[ch*32 +: 32] = d;
    io_width[ch*32 +: 32] = w;
    io_gap[ch*32 +: 32]   = g;
    io_repeat[ch*16 +: 16] = r[15:0];
  endtask

  // Returns 1ns after the edge that sampled the trigger (cycle t, k=0).
  task automatic trig(input logic [3:0] mask);
    @(negedge io_clk);
    io_en = mask;
    @(posedge io_clk);
    #1;
    io_en = 4'b0;
  endtask

  task automatic step();
    @(posedge io_clk);
    #1;
  endtask

  task automatic test_reset();
    io_rst = 1'b1;
    io_en = '0; io_dis = '0; io_defaultLevel = 4'b0110;
    io_delay = '0; io_width = '0; io_gap = '0; io_repeat = '0;
    #2;
    total++;
    if (io_pulseOut !== 4'b0110) begin bad++; $display("FAIL reset_out got=%b exp=%b", io_pulseOut, 4'b0110); end
    total++;
    if (io_busy !== 4'b0000) begin bad++; $display("FAIL reset_busy got=%b exp=0000", io_busy); end
    total++;
    if (io_done !== 4'b0000) begin bad++; $display("FAIL reset_done got=%b exp=0000", io_done); end
    @(negedge io_clk);
    io_rst = 1'b0;
    step();
  endtask

  task automatic test_ch0_train();
    logic eo, eb, ed;
    set_cfg(0, 1'b0, 3, 5, 2, 2);
    trig(4'b0001);
    for (int k = 0; k <= 18; k++) begin
      if (k > 0) step();
      eo = ((k >= 4) && (k <= 8)) || ((k >= 11) && (k <= 15));
      eb = (k >= 1) && (k <= 15);
      ed = (k == 15);
      total++;
      if (io_pulseOut[0] !== eo) begin bad++; $display("FAIL ch0_out k=%0d got=%b exp=%b", k, io_pulseOut[0], eo); end
      total++;
      if (io_busy[0] !== eb) begin bad++; $display("FAIL ch0_busy k=%0d got=%b exp=%b", k, io_busy[0], eb); end
      total++;
      if (io_done[0] !== ed) begin bad++; $display("FAIL ch0_done k=%0d got=%b exp=%b", k, io_done[0], ed); end
    end
  endtask

  task automatic test_ch1_single();
    set_cfg(1, 1'b0, 0, 1, 0, 1);
    trig(4'b0010);
    step();
    total++;
    if ({io_pulseOut[1], io_done[1], io_busy[1]} !== 3'b111) begin
      bad++; $display("FAIL ch1_pulse got=%b%b%b exp=111", io_pulseOut[1], io_done[1], io_busy[1]);
    end
    step();
    total++;
    if ({io_pulseOut[1], io_done[1], io_busy[1]} !== 3'b000) begin
      bad++; $display("FAIL ch1_after got=%b%b%b exp=000", io_pulseOut[1], io_done[1], io_busy[1]);
    end
    set_cfg(1, 1'b0, 0, 0, 0, 1);
    trig(4'b0010);
    for (int k = 1; k <= 3; k++) begin
      step();
      total++;
      if ({io_pulseOut[1], io_done[1], io_busy[1]} !== 3'b000) begin
        bad++; $display("FAIL ch1_w0 k=%0d got=%b%b%b exp=000", k, io_pulseOut[1], io_done[1], io_busy[1]);
      end
    end
  endtask

  task automatic test_ch2_continuous_dis();
    logic eo;
    set_cfg(2, 1'b1, 0, 2, 2, 0);
    trig(4'b0100);
    for (int k = 1; k <= 10; k++) begin
      step();
      eo = (((k - 1) / 2) % 2) != 0;
      total++;
      if (io_pulseOut[2] !== eo) begin bad++; $display("FAIL ch2_out k=%0d got=%b exp=%b", k, io_pulseOut[2], eo); end
    end
    io_dis[2] = 1'b1;
    #1;
    total++;
    if (io_pulseOut[2] !== 1'b1) begin bad++; $display("FAIL ch2_dis_comb got=%b exp=1", io_pulseOut[2]); end
    step();
    total++;
    if ({io_pulseOut[2], io_busy[2], io_done[2]} !== 3'b100) begin
      bad++; $display("FAIL ch2_dis got=%b%b%b exp=100", io_pulseOut[2], io_busy[2], io_done[2]);
    end
    io_dis[2] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if ({io_pulseOut[2], io_busy[2], io_done[2]} !== 3'b100) begin
        bad++; $display("FAIL ch2_idle k=%0d got=%b%b%b exp=100", k, io_pulseOut[2], io_busy[2], io_done[2]);
      end
    end
  endtask

  task automatic test_retrig();
    int act_cnt, done_k, done_cnt, exp_cnt;
`ifdef SIGPULSE_MC_RETRIG_EN
    exp_cnt = 13;
`else
    exp_cnt = 10;
`endif
    act_cnt = 0; done_k = -1; done_cnt = 0;
    set_cfg(3, 1'b0, 0, 10, 0, 1);
    trig(4'b1000);
    for (int k = 1; k <= 20; k++) begin
      step();
      if (io_pulseOut[3]) act_cnt++;
      if (io_done[3]) begin done_cnt++; done_k = k; end
      if (k == 2) io_en[3] = 1'b1;
      if (k == 3) io_en[3] = 1'b0;
    end
    total++;
    if (act_cnt != exp_cnt) begin bad++; $display("FAIL retrig_active got=%0d exp=%0d", act_cnt, exp_cnt); end
    total++;
    if (done_k != exp_cnt) begin bad++; $display("FAIL retrig_done_cycle got=%0d exp=%0d", done_k, exp_cnt); end
    total++;
    if (done_cnt != 1) begin bad++; $display("FAIL retrig_done_count got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_rst_mid_and_en_dis();
    set_cfg(3, 1'b0, 0, 3, 5, 0);
    set_cfg(0, 1'b0, 1, 20, 0, 1);
    trig(4'b1001);
    repeat (5) step();
    total++;
    if ({io_pulseOut[3], io_busy[3], io_pulseOut[0], io_busy[0]} !== 4'b0111) begin
      bad++; $display("FAIL mid_run got=%b%b%b%b exp=0111", io_pulseOut[3], io_busy[3], io_pulseOut[0], io_busy[0]);
    end
    io_rst = 1'b1;
    #1;
    total++;
    if (io_pulseOut !== 4'b0100) begin bad++; $display("FAIL rst_out got=%b exp=0100", io_pulseOut); end
    total++;
    if ((io_busy !== 4'b0000) || (io_done !== 4'b0000)) begin
      bad++; $display("FAIL rst_busy_done got=%b/%b exp=0000/0000", io_busy, io_done);
    end
    @(negedge io_clk);
    io_rst = 1'b0;
    repeat (3) step();
    total++;
    if ((io_pulseOut !== 4'b0100) || (io_busy !== 4'b0000)) begin
      bad++; $display("FAIL post_rst got=%b/%b exp=0100/0000", io_pulseOut, io_busy);
    end
    set_cfg(1, 1'b1, 0, 4, 0, 1);
    @(negedge io_clk);
    io_en[1] = 1'b1;
    io_dis[1] = 1'b1;
    @(posedge io_clk);
    #1;
    io_en[1] = 1'b0;
    io_dis[1] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      total++;
      if ({io_pulseOut[1], io_busy[1], io_done[1]} !== 3'b100) begin
        bad++; $display("FAIL en_dis k=%0d got=%b%b%b exp=100", k, io_pulseOut[1], io_busy[1], io_done[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ch0_train();
    test_ch1_single();
    test_ch2_continuous_dis();
    test_retrig();
    test_rst_mid_and_en_dis();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
